// File: rtl/swap_sequencer_if.sv
// Handshake and register-file port bundle between the control unit, the
// swap sequencer and the register file.
interface swap_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  // Control unit / register file side.
  modport master (
    output start, mode, addr_a, addr_b, rd_data_a, rd_data_b,
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  start, mode, addr_a, addr_b, rd_data_a, rd_data_b,
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/swap_sequencer.sv
// Multi-cycle register exchange engine: reads two registers in one cycle,
// then writes them back swapped or copied through the single write port.
module swap_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_f,
  swap_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_A,
    WR_B,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SWAP  = 2'b00;
  localparam logic [1:0] MODE_CP_AB = 2'b10;
  localparam logic [1:0] MODE_ILL   = 2'b11;

  state_t            state;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] hold_a;
  logic [DATA_W-1:0] hold_b;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_from_b;

  assign bus.rd_addr_a = a_q;
  assign bus.rd_addr_b = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  // Write data is picked from the operand snapshot, forced to zero when idle.
  assign bus.wr_data   = !wr_en_q ? '0 : (wr_from_b ? hold_b : hold_a);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_from_b <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.addr_a;
            b_q    <= bus.addr_b;
            mode_q <= bus.mode;
            busy_q <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          // Both operands are snapshotted before any write, so a swap is safe.
          hold_a <= bus.rd_data_a;
          hold_b <= bus.rd_data_b;
          if (mode_q == MODE_ILL) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= DONE;
          end else if (a_q == b_q) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else if (mode_q == MODE_CP_AB) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= b_q;
            wr_from_b <= 1'b0;
            state     <= WR_B;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= a_q;
            wr_from_b <= 1'b1;
            state     <= WR_A;
          end
        end
        WR_A: begin
          if (mode_q == MODE_SWAP) begin
            wr_addr_q <= b_q;
            wr_from_b <= 1'b0;
            state     <= WR_B;
          end else begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_from_b <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        WR_B: begin
          wr_en_q   <= 1'b0;
          wr_addr_q <= '0;
          wr_from_b <= 1'b0;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          wr_en_q   <= 1'b0;
          wr_addr_q <= '0;
          wr_from_b <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/swap_sequencer.md
# swap_sequencer

Multi-cycle register-exchange engine for the SISC datapath. It generalises the swap address select into a parametrised, self-sequencing unit. On a start request it latches two register addresses, reads both operands through the register file read ports, and writes them back exchanged or copied one write per cycle through the single register file write port. It sits between the control unit (start/busy/done handshake) and the register file.

## Interface
- ADDR_W, 4, register address width (register file depth = 2^ADDR_W)
- DATA_W, 32, register data width
- clk  in  1  system clock; all state updates on rising edge
- rst_f  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 swap (a↔b), 01 copy b→a, 10 copy a→b, 11 illegal
- addr_a  in  ADDR_W  first register address (Rs)
- addr_b  in  ADDR_W  second register address (Rt)
- rd_addr_a  out  ADDR_W  to register file read port A (latched addr_a)
- rd_addr_b  out  ADDR_W  to register file read port B (latched addr_b)
- rd_data_a  in  DATA_W  combinational read data for rd_addr_a
- rd_data_b  in  DATA_W  combinational read data for rd_addr_b
- wr_en  out  1  register file write strobe
- wr_addr  out  ADDR_W  register file write address
- wr_data  out  DATA_W  register file write data
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when mode = 11

## Operation
- States: IDLE, READ, WR_A, WR_B, DONE.
- IDLE: if start = 1, latch addr_a, addr_b and mode, then go to READ. Otherwise stay in IDLE.
- READ: rd_addr_a/b present the latched addresses. Capture rd_data_a into hold_a and rd_data_b into hold_b at the end of the cycle. Next state:
  - mode 11 → DONE with err
  - latched addr_a == latched addr_b → DONE, no writes, err = 0
  - mode 00 or 01 → WR_A
  - mode 10 → WR_B
- WR_A: wr_en = 1, wr_addr = latched a, wr_data = hold_b. Next state: WR_B if mode 00, else DONE.
- WR_B: wr_en = 1, wr_addr = latched b, wr_data = hold_a. Next state: DONE.
- DONE: done = 1 for one cycle; err = 1 only if mode was 11. Next state: IDLE.
- hold_a/hold_b are captured before any write, so a swap never sees its own first write.
- start, addr_* and mode are ignored in every state except IDLE. No queuing.
- Reset (asynchronous, any state): state = IDLE. Outputs go to 0 immediately, with no clock needed: busy, done, err, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b. Latched addresses, mode and hold registers also clear to 0. A reset during WR_A abandons the operation; any write already performed stands.
- wr_addr and wr_data are 0 whenever wr_en = 0.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: READ.
- Swap, distinct addresses: WR_A in cycle 2, WR_B in cycle 3, done in cycle 4. Total latency 4 cycles from start to done.
- Copy modes: one write in cycle 2, done in cycle 3.
- Equal addresses or illegal mode: done in cycle 2, zero writes.
- busy is high in every cycle from READ through DONE inclusive.
- The earliest next start is sampled in the cycle after DONE (IDLE). Back-to-back operations therefore repeat every 5 cycles for a swap.
- rd_data_* must be valid within the READ cycle. The register file read path is combinational.

## Test plan
- Reset: hold rst_f = 0 mid-WR_A → all outputs read 0 immediately. After release: IDLE, busy = 0, no wr_en pulse.
- Swap: R3 = 0x11111111, R9 = 0x22222222; start with mode 00, a = 3, b = 9. Required: cycle 2 write (3, 0x22222222), cycle 3 write (9, 0x11111111), done in cycle 4, err = 0. Final R3 = 0x22222222, R9 = 0x11111111.
- Copy: mode 01, a = 5, b = 7, R7 = 0xDEADBEEF → single write (5, 0xDEADBEEF) in cycle 2, done in cycle 3, R7 unchanged. Repeat with mode 10 → single write (7, old R5).
- Equal addresses: mode 00, a = b = 4 → wr_en never asserted, done in cycle 2, err = 0.
- Illegal mode: mode 11 → no writes, done and err both high in cycle 2 for exactly one cycle.
- Start while busy: assert start with new addresses in cycles 1–4 → ignored, original swap completes unchanged. A start held through IDLE is accepted again in cycle 5.
